// File: rtl/i2s_rx_peripheral_if.sv
// picosoc iomem bus bundle for the I2S receiver: master drives requests,
// slave returns a one-cycle ready pulse with registered read data.
interface i2s_rx_peripheral_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
                  input  iomem_ready, iomem_rdata);
  modport slave  (input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
                  output iomem_ready, iomem_rdata);
endinterface

// File: rtl/i2s_rx_peripheral.sv
// Philips I2S receiver: synchronises the external sck/ws/sd, assembles stereo
// frames and queues them in a FIFO drained by CPU reads of the DATA register.
module i2s_rx_peripheral #(
  parameter logic [15:0] ADDR   = 16'h6100,
  parameter int          WIDTH  = 16,
  parameter int          DEPTH  = 16,
  parameter int          THRESH = 8
) (
  input  logic                 ck,
  input  logic                 rst,
  i2s_rx_peripheral_if.slave   bus,
  input  logic                 i2s_sck,
  input  logic                 i2s_ws,
  input  logic                 i2s_sd,
  output logic                 irq
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [4:0]    WBITS = 5'(WIDTH);
  localparam logic [CW-1:0] FULLC = CW'(DEPTH);

  logic [2:0]    sck_q, sck_d;
  logic [1:0]    ws_q, ws_d, sd_q, sd_d;
  logic          ws_prev_q, ws_prev_d, synced_q, synced_d, have_left_q, have_left_d;
  logic [4:0]    bitcnt_q, bitcnt_d;
  logic [15:0]   sh_q, sh_d, left_q, left_d, word;
  logic          en_q, en_d, ovf_q, ovf_d, ready_q, ready_d, irq_q, irq_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d, rd_val;
  logic [31:0]   mem_q [DEPTH];
  logic          rise, ws_edge, push, do_push, pop, flush, ack, wr, empty, full;
  logic [1:0]    rsel;
  logic [3:0]    bidx;
  logic          unused;

  assign unused = ^{bus.iomem_addr[15:4], bus.iomem_addr[1:0], bus.iomem_wdata[31:3]};

  always_comb begin
    sck_d = {sck_q[1:0], i2s_sck};
    ws_d  = {ws_q[0], i2s_ws};
    sd_d  = {sd_q[0], i2s_sd};
    rise    = sck_q[1] & ~sck_q[2];
    ws_edge = rise & (ws_q[1] != ws_prev_q);
    ws_prev_d = rise ? ws_q[1] : ws_prev_q;

    // Bits land MSB-first straight into their 16-bit aligned position,
    // so short words come out left-justified with zero fill for free.
    bidx = 4'(5'd15 - bitcnt_q);
    word = sh_q;
    if (bitcnt_q < WBITS) word[bidx] = sd_q[1];

    sh_d = sh_q; bitcnt_d = bitcnt_q; left_d = left_q;
    have_left_d = have_left_q; synced_d = synced_q; push = 1'b0;
    if (rise) begin
      if (bitcnt_q < WBITS) begin
        sh_d = word;
        bitcnt_d = bitcnt_q + 5'd1;
      end
      if (ws_edge) begin
        sh_d = '0; bitcnt_d = '0; synced_d = 1'b1;
        if (ws_q[1]) begin
          // Only a left slot that began after a seen edge counts as complete.
          if (synced_q) begin
            left_d = word; have_left_d = 1'b1;
          end
        end else begin
          push = have_left_q;
          have_left_d = 1'b0;
        end
      end
    end
    if (!en_q) begin
      sh_d = '0; bitcnt_d = '0; have_left_d = 1'b0; synced_d = 1'b0; push = 1'b0;
    end

    ack   = bus.iomem_valid & (bus.iomem_addr[31:16] == ADDR) & ~ready_q;
    wr    = |bus.iomem_wstrb;
    rsel  = bus.iomem_addr[3:2];
    empty = (cnt_q == '0);
    full  = (cnt_q == FULLC);
    pop   = ack & ~wr & (rsel == 2'd0) & ~empty;
    flush = ack & wr & (rsel == 2'd2) & bus.iomem_wdata[1];
    do_push = push & (~full | pop);

    case (rsel)
      2'd0:    rd_val = empty ? 32'h0 : mem_q[rp_q];
      2'd1:    rd_val = {16'h0, 8'(cnt_q), 5'h0, ovf_q, full, empty};
      2'd2:    rd_val = {31'h0, en_q};
      default: rd_val = 32'h0;
    endcase
    ready_d = ack;
    rdata_d = (ack & ~wr) ? rd_val : 32'h0;

    en_d = (ack & wr & (rsel == 2'd2)) ? bus.iomem_wdata[0] : en_q;
    ovf_d = ovf_q;
    if (ack & wr & (rsel == 2'd1) & bus.iomem_wdata[2]) ovf_d = 1'b0;
    if (push & ~do_push) ovf_d = 1'b1;

    wp_d  = wp_q + AW'(do_push);
    rp_d  = rp_q + AW'(pop);
    cnt_d = cnt_q + CW'(do_push) - CW'(pop);
    if (flush) begin
      wp_d = '0; rp_d = '0; cnt_d = '0;
    end
    irq_d = (32'(cnt_q) >= THRESH);
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      sck_q <= '0; ws_q <= '0; sd_q <= '0;
      ws_prev_q <= 1'b0; synced_q <= 1'b0; have_left_q <= 1'b0;
      bitcnt_q <= '0; sh_q <= '0; left_q <= '0;
      en_q <= 1'b0; ovf_q <= 1'b0; ready_q <= 1'b0; irq_q <= 1'b0;
      wp_q <= '0; rp_q <= '0; cnt_q <= '0; rdata_q <= '0;
    end else begin
      sck_q <= sck_d; ws_q <= ws_d; sd_q <= sd_d;
      ws_prev_q <= ws_prev_d; synced_q <= synced_d; have_left_q <= have_left_d;
      bitcnt_q <= bitcnt_d; sh_q <= sh_d; left_q <= left_d;
      en_q <= en_d; ovf_q <= ovf_d; ready_q <= ready_d; irq_q <= irq_d;
      wp_q <= wp_d; rp_q <= rp_d; cnt_q <= cnt_d; rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge ck) begin
    if (do_push & ~flush) mem_q[wp_q] <= {left_q, word};
  end

  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;
  assign irq = irq_q;
endmodule

// File: tb/tb_i2s_rx_peripheral.sv
// Directed bench: I2S frames and bus accesses are issued from one process,
// expected read data is queued and checked by a monitor on each ready pulse.
module tb_i2s_rx_peripheral;
  logic ck = 1'b0, rst = 1'b0;
  logic i2s_sck = 1'b0, i2s_ws = 1'b0, i2s_sd = 1'b0;
  logic irq;
  int checks = 0, errors = 0;

  typedef struct {
    logic [31:0] val;
    bit          chk;
    string       nm;
  } exp_t;
  exp_t expq[$];
  exp_t mon_e;

  i2s_rx_peripheral_if bus();

  i2s_rx_peripheral #(.ADDR(16'h6100), .WIDTH(16), .DEPTH(16), .THRESH(8)) dut (
    .ck(ck), .rst(rst), .bus(bus),
    .i2s_sck(i2s_sck), .i2s_ws(i2s_ws), .i2s_sd(i2s_sd), .irq(irq)
  );

  always #5 ck = ~ck;

  always @(negedge ck) begin
    if (rst && bus.iomem_ready) begin
      if (expq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ready: rdata %h with nothing expected", bus.iomem_rdata);
      end else begin
        mon_e = expq.pop_front();
        if (mon_e.chk) begin
          checks++;
          if (bus.iomem_rdata !== mon_e.val) begin
            errors++;
            $display("FAIL %s: got %h expected %h", mon_e.nm, bus.iomem_rdata, mon_e.val);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic bus_xfer(input logic [31:0] addr, input logic [3:0] wstrb,
                          input logic [31:0] wdata);
    bit got = 0;
    @(negedge ck);
    bus.iomem_valid = 1'b1; bus.iomem_addr = addr;
    bus.iomem_wstrb = wstrb; bus.iomem_wdata = wdata;
    for (int i = 0; i < 10; i++) begin
      @(negedge ck);
      if (bus.iomem_ready) begin got = 1; break; end
    end
    bus.iomem_valid = 1'b0; bus.iomem_wstrb = 4'h0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL bus_timeout: addr %h no ready within 10 cycles", addr);
      void'(expq.pop_back());
    end
  endtask

  task automatic rd(input logic [1:0] r, input logic [31:0] exp, input string nm);
    expq.push_back('{exp, 1'b1, nm});
    bus_xfer({16'h6100, 12'h0, r, 2'b00}, 4'h0, 32'h0);
  endtask

  task automatic wr(input logic [1:0] r, input logic [31:0] d);
    expq.push_back('{32'h0, 1'b0, "write"});
    bus_xfer({16'h6100, 12'h0, r, 2'b00}, 4'hF, d);
  endtask

  // Philips timing: ws switches on the last (LSB) bit of the current word.
  task automatic i2s_word(input logic [31:0] data, input int n, input logic ch,
                          input bit toggle);
    for (int j = 0; j < n; j++) begin
      @(negedge ck);
      i2s_sck = 1'b0; i2s_sd = data[n-1-j];
      i2s_ws = (toggle && j == n-1) ? ~ch : ch;
      repeat (4) @(negedge ck);
      i2s_sck = 1'b1;
      repeat (3) @(negedge ck);
    end
  endtask

  task automatic frame(input logic [31:0] l, input logic [31:0] r, input int n);
    i2s_word(l, n, 1'b0, 1'b1);
    i2s_word(r, n, 1'b1, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen_rdy, seen_dat;
    bus.iomem_valid = 1'b0; bus.iomem_wstrb = 4'h0;
    bus.iomem_addr = 32'h0; bus.iomem_wdata = 32'h0;
    repeat (3) @(negedge ck);
    chk("reset_ready", {31'h0, bus.iomem_ready}, 32'h0);
    chk("reset_rdata", bus.iomem_rdata, 32'h0);
    chk("reset_irq", {31'h0, irq}, 32'h0);
    rst = 1'b1;
    rd(2'd1, 32'h0000_0001, "reset_status");

    // partial first frame, then 32/12/24-bit slot frames
    wr(2'd2, 32'h1);
    i2s_word(32'h3FF, 10, 1'b0, 1'b1);
    i2s_word(32'hFFFF, 16, 1'b1, 1'b1);
    frame(32'h1234_FFFF, 32'hABCD_0000, 32);
    i2s_word(32'hABC, 12, 1'b0, 1'b1);
    i2s_word(32'h5A5A, 16, 1'b1, 1'b1);
    frame(32'h0012_3456, 32'h0098_76EF, 24);
    rd(2'd1, 32'h0000_0300, "status_three");
    rd(2'd0, 32'h1234_ABCD, "data_32bit_slot");
    rd(2'd0, 32'hABC0_5A5A, "data_short_word");
    rd(2'd0, 32'h1234_9876, "data_24bit_slot");
    rd(2'd1, 32'h0000_0001, "status_drained");

    // fill past DEPTH, irq threshold, sticky overflow
    for (int i = 0; i < 17; i++) begin
      frame(32'h1000 + i, 32'h2000 + i, 16);
      if (i == 6) begin
        repeat (2) @(negedge ck);
        chk("irq_below_thresh", {31'h0, irq}, 32'h0);
      end
      if (i == 7) begin
        repeat (2) @(negedge ck);
        chk("irq_at_thresh", {31'h0, irq}, 32'h1);
      end
    end
    rd(2'd1, 32'h0000_1006, "status_full_ovf");
    wr(2'd1, 32'h4);
    rd(2'd1, 32'h0000_1002, "status_ovf_cleared");
    for (int i = 0; i < 16; i++)
      rd(2'd0, {16'h1000 + 16'(i), 16'h2000 + 16'(i)}, $sformatf("data_order_%0d", i));
    repeat (2) @(negedge ck);
    chk("irq_after_drain", {31'h0, irq}, 32'h0);
    rd(2'd1, 32'h0000_0001, "status_after_drain");

    // flush
    frame(32'h0111, 32'h0222, 16);
    frame(32'h0333, 32'h0444, 16);
    rd(2'd1, 32'h0000_0200, "status_pre_flush");
    wr(2'd2, 32'h3);
    rd(2'd1, 32'h0000_0001, "status_post_flush");
    rd(2'd2, 32'h0000_0001, "ctrl_flush_reads0");

    // unmatched address, reserved reg, empty DATA read
    frame(32'h5555, 32'hAAAA, 16);
    @(negedge ck);
    bus.iomem_valid = 1'b1; bus.iomem_addr = 32'h6200_0000; bus.iomem_wstrb = 4'h0;
    seen_rdy = 0; seen_dat = 0;
    repeat (6) begin
      @(negedge ck);
      if (bus.iomem_ready) seen_rdy = 1;
      if (bus.iomem_rdata != 0) seen_dat = 1;
    end
    bus.iomem_valid = 1'b0;
    chk("nosel_ready", {31'h0, seen_rdy}, 32'h0);
    chk("nosel_rdata", {31'h0, seen_dat}, 32'h0);
    rd(2'd1, 32'h0000_0100, "status_after_nosel");
    rd(2'd3, 32'h0000_0000, "reserved_reads0");
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd0, 32'h5555_AAAA, "data_single");
    rd(2'd0, 32'h0000_0000, "data_empty_read");
    rd(2'd1, 32'h0000_0001, "status_empty_no_pop");

    // reset mid-slot with 3 entries queued
    frame(32'h1111, 32'h2222, 16);
    frame(32'h3333, 32'h4444, 16);
    frame(32'h5555, 32'h6666, 16);
    rd(2'd1, 32'h0000_0300, "status_pre_reset");
    i2s_word(32'hFF, 8, 1'b0, 1'b0);
    @(negedge ck);
    rst = 1'b0;
    @(negedge ck);
    chk("midreset_ready", {31'h0, bus.iomem_ready}, 32'h0);
    chk("midreset_rdata", bus.iomem_rdata, 32'h0);
    chk("midreset_irq", {31'h0, irq}, 32'h0);
    repeat (2) @(negedge ck);
    rst = 1'b1;
    rd(2'd1, 32'h0000_0001, "status_post_reset");
    rd(2'd2, 32'h0000_0000, "ctrl_post_reset");
    wr(2'd2, 32'h1);
    i2s_word(32'h0F, 8, 1'b0, 1'b1);
    i2s_word(32'h7777, 16, 1'b1, 1'b1);
    frame(32'hCAFE, 32'hBEEF, 16);
    rd(2'd0, 32'hCAFE_BEEF, "data_post_reset");
    rd(2'd1, 32'h0000_0001, "status_final");

    repeat (4) @(negedge ck);
    chk("scoreboard_drained", 32'(expq.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
